apb_master: RTL
===============

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, max ACCESS cycles before abort (used only with timeout compiled in).
REQ-004 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports cmd_valid_i input 1, cmd_ready_o output 1: command handshake.
REQ-007 SHALL have ports cmd_addr_i input ADDR_W, cmd_write_i input 1, cmd_wdata_i input DATA_W: command payload.
REQ-008 SHALL have ports rsp_valid_o output 1, rsp_ready_i input 1: response handshake.
REQ-009 SHALL have ports rsp_rdata_o output DATA_W, rsp_err_o output 1: response payload.
REQ-010 SHALL have ports psel_o, penable_o, pwrite_o output 1; paddr_o output ADDR_W; pwdata_o output DATA_W: APB request.
REQ-011 SHALL have ports prdata_i input DATA_W, pready_i input 1: APB completion.

Function
REQ-012 SHALL implement FSM with states IDLE, SETUP, ACCESS, RESP.
REQ-013 cmd_ready_o SHALL equal (state==IDLE); a command is accepted when cmd_valid_i && cmd_ready_o at a rising edge, moving to SETUP.
REQ-014 On accept, SHALL register cmd_addr_i, cmd_write_i, cmd_wdata_i onto paddr_o, pwrite_o, pwdata_o, held stable until next accept.
REQ-015 SETUP: psel_o=1, penable_o=0, exactly one cycle, then ACCESS.
REQ-016 ACCESS: psel_o=1, penable_o=1; SHALL remain in ACCESS while pready_i=0, with no upper bound unless timeout is compiled in.
REQ-017 ACCESS with pready_i=1: SHALL capture prdata_i into rsp_rdata_o for reads (0 for writes), rsp_err_o=0, go to RESP; psel_o/penable_o=0 next cycle.
REQ-018 RESP: rsp_valid_o=1, payload stable; on rsp_ready_i=1 go to IDLE; rsp_valid_o=0 in all other states.
REQ-019 Minimum latency SHALL be 3 cycles, accept edge to rsp_valid_o high (pready_i high on first ACCESS cycle).
REQ-020 pready_i, prdata_i SHALL be ignored outside ACCESS.
REQ-021 No new command SHALL be accepted before the previous response is consumed (single outstanding transfer).
REQ-022 Unreachable state encodings SHALL return to IDLE.

Reset
REQ-023 reset SHALL immediately force IDLE and drive psel_o=0, penable_o=0, pwrite_o=0, paddr_o=0, pwdata_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, cmd_ready_o=1 after release.
REQ-024 Reset mid-transfer SHALL discard the transfer without a response.

Configuration
REQ-025 Macro APB_MASTER_TIMEOUT_EN SHALL enable ACCESS timeout.
REQ-026 With it: counter clears on entering ACCESS, increments per ACCESS cycle with pready_i=0; on reaching TIMEOUT_CYCLES SHALL drop psel_o/penable_o, go to RESP with rsp_err_o=1, rsp_rdata_o=0.
REQ-027 pready_i=1 on the same cycle the limit is reached SHALL win (normal completion, rsp_err_o=0).
REQ-028 Without it: no counter logic, rsp_err_o tied 0, ACCESS waits indefinitely.

Structure
REQ-029 Package apb_pkg SHALL hold the FSM state enum and default ADDR_W/DATA_W constants, shared with the APB slave.
REQ-030 Sub-module apb_master_timer SHALL implement the timeout counter, instantiated only under APB_MASTER_TIMEOUT_EN.

Verification
REQ-031 Write addr 0x004 data 0xDEADBEEF, pready_i=1 in ACCESS cycle 1 -> psel 2 cycles, penable 1 cycle, rsp_valid_o 3 cycles after accept, rsp_err_o=0.
REQ-032 Read addr 0x004, pready_i after 3 wait cycles with prdata_i=0xDEADBEEF -> penable_o high 4 cycles, rsp_rdata_o=0xDEADBEEF.
REQ-033 Back-to-back commands, rsp_ready_i held 0 for 5 cycles -> cmd_ready_o=0 and rsp payload stable throughout; second command accepted only in IDLE.
REQ-034 Timeout on, pready_i never high, TIMEOUT_CYCLES=16 -> after 16 ACCESS cycles psel_o=0, rsp_err_o=1, rsp_rdata_o=0.
REQ-035 Assert reset during ACCESS -> psel_o/penable_o fall asynchronously, no rsp_valid_o, cmd_ready_o=1 after release.
REQ-036 Connect to APB slave with memory, write 0x12345678 to addr 0x3 then read addr 0x3 -> read returns 0x12345678.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer FSM states and default bus widths,
// used by both the APB master and the APB slave.
package apb_pkg;

  localparam int APB_ADDR_W = 10;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // True while the master owns the bus (psel asserted).
  function automatic logic apb_bus_active(input apb_state_e st);
    return (st == ST_SETUP) || (st == ST_ACCESS);
  endfunction

endpackage

// File: rtl/apb_master_timer.sv
// ACCESS-phase watchdog for apb_master: counts wait-state cycles and flags
// the cycle on which the count reaches TIMEOUT_CYCLES.
module apb_master_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the wait cycle whose increment would reach the limit.
  assign expire_o = inc_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: command/response handshake in, APB out.
// Optional ACCESS timeout is compiled in with APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic              cmd_write_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i
);

  if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("apb_master: TIMEOUT_CYCLES must be at least 1");
  end

  apb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              timeout;

`ifdef APB_MASTER_TIMEOUT_EN
  logic rsp_err_q, rsp_err_d;

  apb_master_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (state_q == ST_SETUP),
    .inc_i    ((state_q == ST_ACCESS) && !pready_i),
    .expire_o (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          state_d  = ST_SETUP;
          paddr_d  = cmd_addr_i;
          pwrite_d = cmd_write_i;
          pwdata_d = cmd_wdata_i;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // Completion takes priority over a timeout expiring in the same cycle.
        if (pready_i) begin
          state_d     = ST_RESP;
          rsp_rdata_d = pwrite_q ? '0 : prdata_i;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
        end else if (timeout) begin
          state_d     = ST_RESP;
          rsp_rdata_d = '0;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_err_d   = 1'b1;
`endif
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_rdata_q <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_MASTER_TIMEOUT_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  // All handshake/strobe outputs decode directly from the registered state,
  // so reset drops them immediately.
  assign cmd_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign psel_o      = apb_bus_active(state_q);
  assign penable_o   = (state_q == ST_ACCESS);
  assign pwrite_o    = pwrite_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign rsp_rdata_o = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
  assign rsp_err_o   = rsp_err_q;
`else
  assign rsp_err_o   = 1'b0;
`endif

endmodule
